keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 172 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low key matrix; debounces press and release, reports the
// row*4+col code with a one-cycle valid pulse and optional auto-repeat.
// state    | meaning
// SCAN     | walk the columns, sample rows on the last dwell cycle
// DEBOUNCE | count consecutive low samples of the latched row
// PRESSED  | key accepted, repeat timer running
// RELEASE  | count consecutive high samples before resuming the scan
module keypad_scanner #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int COL_DWELL       = 4,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_RATE     = 100
) (
  input  logic       clk_scan,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DB_MAX  = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int DW_MAX  = (COL_DWELL < 1) ? 1 : COL_DWELL;
  localparam int RD_LOAD = (REPEAT_DELAY < 1) ? 0 : REPEAT_DELAY - 1;
  localparam int RR_LOAD = (REPEAT_RATE < 1) ? 0 : REPEAT_RATE - 1;
  localparam int RP_MAX  = (RD_LOAD > RR_LOAD) ? RD_LOAD : RR_LOAD;
  localparam int DB_W    = $clog2(DB_MAX + 1);
  localparam int DW_W    = (DW_MAX > 1) ? $clog2(DW_MAX) : 1;
  localparam int RP_W    = (RP_MAX > 0) ? $clog2(RP_MAX + 1) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_MAX - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DW_MAX - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic [RP_W-1:0] rep_q, rep_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic [3:0]      sync_q, row_q;

  logic            row_hit;
  logic [1:0]      low_idx;
  logic            row_bit;

  assign row_hit = ~&row_q;
  assign row_bit = row_q[row_idx_q];

  always_comb begin
    low_idx = 2'd3;
    if (!row_q[0])      low_idx = 2'd0;
    else if (!row_q[1]) low_idx = 2'd1;
    else if (!row_q[2]) low_idx = 2'd2;
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    row_idx_d = row_idx_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    unique case (state_q)
      S_SCAN: begin
        if (dwell_q == DW_LAST) begin
          if (row_hit) begin
            state_d   = S_DEBOUNCE;
            row_idx_d = low_idx;
            cnt_d     = '0;
          end else begin
            col_d   = col_q + 2'd1;
            dwell_d = '0;
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      S_DEBOUNCE: begin
        if (row_bit) begin
          state_d = S_SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_PRESSED;
          code_d  = {row_idx_q, col_q};
          valid_d = 1'b1;
          held_d  = 1'b1;
          rep_d   = RP_W'(RD_LOAD);
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      S_PRESSED: begin
        if (row_bit) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (REPEAT_DELAY > 0) begin
          if (rep_q == '0) begin
            valid_d = 1'b1;
            rep_d   = RP_W'(RR_LOAD);
          end else begin
            rep_d = rep_q - RP_W'(1);
          end
        end
      end
      S_RELEASE: begin
        // A low sample here is a contact glitch: resume holding, restart repeat.
        if (!row_bit) begin
          state_d = S_PRESSED;
          rep_d   = RP_W'(RD_LOAD);
        end else if (cnt_q == DB_LAST) begin
          state_d = S_SCAN;
          held_d  = 1'b0;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  always_ff @(posedge clk_scan) begin
    if (rst) begin
      // Synchronizer clears to the released (pulled-up) level.
      sync_q    <= 4'hF;
      row_q     <= 4'hF;
      state_q   <= S_SCAN;
      col_q     <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      rep_q     <= '0;
      row_idx_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      sync_q    <= row_in;
      row_q     <= sync_q;
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      row_idx_q <= row_idx_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model closes row r onto column c for
// every pressed key (r*4+c); cycle n is the n-th cycle after the last reset edge.
module tb_keypad_scanner;

  localparam int DB = 20;

  logic       clk_scan;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [15:0] keys;
  int          cyc;
  int          n_vec;
  int          n_err;

  keypad_scanner #(
    .DEBOUNCE_CYCLES(20),
    .COL_DWELL(4),
    .REPEAT_DELAY(500),
    .REPEAT_RATE(100)
  ) dut (
    .clk_scan (clk_scan),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk_scan = 1'b0;
  always #5 clk_scan = ~clk_scan;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  always @(posedge clk_scan) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input logic [15:0] k);
    @(negedge clk_scan);
    rst  = 1'b1;
    keys = k;
    @(negedge clk_scan);
    @(negedge clk_scan);
    rst = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [15:0] keys;
    int          col;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tv, x, last, np;
    int pq[$];
    int exp_a[4];

    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    keys  = '0;

    vecs[0] = '{"k5",     16'h0020, 1, 4'd5};
    vecs[1] = '{"k0",     16'h0001, 0, 4'd0};
    vecs[2] = '{"k15",    16'h8000, 3, 4'd15};
    vecs[3] = '{"k6_k14", 16'h4040, 2, 4'd6};
    vecs[4] = '{"k14",    16'h4000, 2, 4'd14};
    vecs[5] = '{"k9",     16'h0200, 1, 4'd9};
    vecs[6] = '{"k1_k2",  16'h0006, 1, 4'd1};
    vecs[7] = '{"k4_k8",  16'h0110, 0, 4'd4};

    repeat (3) @(negedge clk_scan);
    rst = 1'b0;
    check("rst_col_out", col_out, 4'b1110);
    check("rst_code", key_code, 4'd0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);

    // Single-press vectors: sample edge 4*col+4, valid DB cycles later.
    for (int v = 0; v < 8; v++) begin
      tv   = 4 * vecs[v].col + 4 + DB;
      x    = tv + 2;
      last = x + 30;
      np   = 0;
      do_reset(vecs[v].keys);
      while (cyc < last) begin
        @(negedge clk_scan);
        if (key_valid === 1'b1) np++;
        if (cyc == tv - 1) check({vecs[v].name, "_early"}, key_valid, 1'b0);
        if (cyc == tv) begin
          check({vecs[v].name, "_valid"}, key_valid, 1'b1);
          check({vecs[v].name, "_code"}, key_code, vecs[v].code);
          check({vecs[v].name, "_held"}, key_held, 1'b1);
        end
        if (cyc == tv + 1) check({vecs[v].name, "_pulse_end"}, key_valid, 1'b0);
        if (cyc == x) keys = '0;
        if (cyc == x + 22) check({vecs[v].name, "_held_pre"}, key_held, 1'b1);
        if (cyc == x + 23) check({vecs[v].name, "_held_fall"}, key_held, 1'b0);
      end
      check({vecs[v].name, "_code_kept"}, key_code, vecs[v].code);
      check({vecs[v].name, "_npulse"}, np, 1);
    end

    // Long hold of key 0: first pulse then repeats at +500, +600, +700.
    exp_a = '{24, 524, 624, 724};
    pq.delete();
    do_reset(16'h0001);
    while (cyc < 850) begin
      @(negedge clk_scan);
      if (key_valid === 1'b1) begin
        pq.push_back(cyc);
        check("rep_code", key_code, 4'd0);
      end
      if (cyc == 774) keys = '0;
      if (cyc == 796) check("rep_held_pre", key_held, 1'b1);
      if (cyc == 797) check("rep_held_fall", key_held, 1'b0);
    end
    check("rep_npulse", pq.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rep_pulse%0d", i), (i < pq.size()) ? pq[i] : -1, exp_a[i]);

    // Bounce on col1: five low samples in DEBOUNCE, then high.
    np = 0;
    do_reset(16'h0020);
    while (cyc < 60) begin
      @(negedge clk_scan);
      if (key_valid === 1'b1) np++;
      if (cyc == 11) keys = '0;
      if (cyc == 13) check("bnc_col_frozen", col_out, 4'b1101);
      if (cyc == 14) check("bnc_col2", col_out, 4'b1011);
      if (cyc == 17) check("bnc_col2_dwell", col_out, 4'b1011);
      if (cyc == 18) check("bnc_col3", col_out, 4'b0111);
      if (cyc == 30) check("bnc_held", key_held, 1'b0);
    end
    check("bnc_npulse", np, 0);

    // Accept key 5, release, then press key 7 and reset at DEBOUNCE count 10.
    np = 0;
    do_reset(16'h0020);
    while (cyc < 71) begin
      @(negedge clk_scan);
      if (key_valid === 1'b1) np++;
      if (cyc == 28) check("abt_first_valid", key_valid, 1'b1);
      if (cyc == 30) keys = '0;
      if (cyc == 52) check("abt_held_pre", key_held, 1'b1);
      if (cyc == 53) check("abt_held_fall", key_held, 1'b0);
      if (cyc == 55) keys = 16'h0080;
      if (cyc == 66) check("abt_col_frozen", col_out, 4'b0111);
    end
    check("abt_npulse_pre", np, 1);
    rst  = 1'b1;
    keys = '0;
    @(negedge clk_scan);
    rst = 1'b0;
    check("abt_col_out", col_out, 4'b1110);
    check("abt_code", key_code, 4'd0);
    check("abt_valid", key_valid, 1'b0);
    check("abt_held", key_held, 1'b0);
    np = 0;
    repeat (40) begin
      @(negedge clk_scan);
      if (key_valid === 1'b1) np++;
    end
    check("abt_npulse_post", np, 0);

    // Release glitch: 8 high cycles during RELEASE, then low again.
    np = 0;
    do_reset(16'h0001);
    while (cyc < 650) begin
      @(negedge clk_scan);
      if (cyc >= 25 && key_valid === 1'b1) np++;
      if (cyc == 24) check("gl_first_valid", key_valid, 1'b1);
      if (cyc == 100) keys = '0;
      if (cyc == 108) keys = 16'h0001;
      if (cyc == 115) check("gl_held_115", key_held, 1'b1);
      if (cyc == 124) check("gl_held_124", key_held, 1'b1);
      if (cyc == 524) check("gl_no_old_rep", key_valid, 1'b0);
      if (cyc == 611) begin
        check("gl_rep_valid", key_valid, 1'b1);
        check("gl_rep_code", key_code, 4'd0);
      end
      if (cyc == 620) keys = '0;
      if (cyc == 642) check("gl_held_pre", key_held, 1'b1);
      if (cyc == 643) check("gl_held_fall", key_held, 1'b0);
    end
    check("gl_npulse", np, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
